// File: rtl/dispatch_ctrl_param.sv
// Dispatch controller: tag free-list, register status table, branch-stall gate, queue routing.
// Optional macro CDB_BYPASS_EN: clears a source's pending flag in the same cycle its producer tag is on the CDB.
module dispatch_ctrl_param #(
    parameter int NUM_QUEUES = 4,
    parameter int TAG_W      = 6,
    parameter int NUM_AREGS  = 32,
    parameter int QSEL_W     = $clog2(NUM_QUEUES)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_dec_valid,
    input  logic [QSEL_W-1:0]     i_dec_qsel,
    input  logic [4:0]            i_dec_rd,
    input  logic                  i_dec_rd_we,
    input  logic [4:0]            i_dec_rs1,
    input  logic [4:0]            i_dec_rs2,
    input  logic                  i_dec_is_branch,
    output logic                  o_dec_ready,
    input  logic [NUM_QUEUES-1:0] i_queue_full,
    output logic [NUM_QUEUES-1:0] o_disp_valid,
    output logic [TAG_W-1:0]      o_rd_tag,
    output logic                  o_rs1_pending,
    output logic                  o_rs2_pending,
    output logic [TAG_W-1:0]      o_rs1_tag,
    output logic [TAG_W-1:0]      o_rs2_tag,
    input  logic                  i_cdb_valid,
    input  logic [TAG_W-1:0]      i_cdb_tag,
    input  logic                  i_cdb_branch,
    input  logic                  i_cdb_branch_taken,
    output logic                  o_rf_wen,
    output logic [4:0]            o_rf_waddr,
    output logic                  o_flush,
    output logic                  o_init_done,
    output logic [TAG_W:0]        o_free_cnt,
    output logic                  o_err,
    output logic [1:0]            o_dbg_state
);
    localparam int NUM_TAGS = 2 ** TAG_W;

    typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, BR_WAIT = 2'd2} state_t;

    state_t                 state;
    logic [TAG_W-1:0]       init_cnt;
    logic [TAG_W-1:0]       head;
    logic [TAG_W-1:0]       tail;
    logic [TAG_W:0]         count;
    logic [TAG_W-1:0]       free_list [NUM_TAGS];
    logic [NUM_AREGS-1:0]   rst_pend;
    logic [TAG_W-1:0]       rst_tag [NUM_AREGS];
    logic                   flush_q;
    logic                   init_done_q;
    logic                   err_q;

    logic                   alloc;
    logic                   qsel_ok;
    logic                   fire;
    logic                   pop;
    logic                   push;
    logic                   cdb_live;
    logic                   list_full;
    logic [NUM_AREGS-1:0]   cdb_hit;

    // Handshake: an instruction transfers in any cycle where o_dec_ready is high; o_dec_ready is
    // the fire term itself and o_disp_valid is its one-hot copy steered to the selected queue.
    assign alloc     = i_dec_rd_we & (i_dec_rd != 5'd0);
    assign qsel_ok   = int'(i_dec_qsel) < NUM_QUEUES;
    assign fire      = (state == RUN) & i_dec_valid & qsel_ok & ~i_queue_full[i_dec_qsel]
                       & (~alloc | (count != '0));
    assign pop       = fire & alloc;
    assign cdb_live  = i_cdb_valid & (state != INIT);
    assign list_full = (count == (TAG_W+1)'(NUM_TAGS));
    assign push      = cdb_live & ~list_full;

    assign o_dec_ready  = fire;
    assign o_disp_valid = fire ? (NUM_QUEUES'(1) << i_dec_qsel) : '0;
    assign o_rd_tag     = free_list[head];
    assign o_flush      = flush_q;
    assign o_init_done  = init_done_q;
    assign o_free_cnt   = count;
    assign o_err        = err_q;
    assign o_dbg_state  = state;

    // Register 0 is never marked pending, so its hit bit stays low.
    always_comb begin
        cdb_hit = '0;
        for (int r = 1; r < NUM_AREGS; r++)
            cdb_hit[r] = cdb_live & rst_pend[r] & (rst_tag[r] == i_cdb_tag);
    end

    always_comb begin
        o_rf_wen   = |cdb_hit;
        o_rf_waddr = 5'd0;
        for (int r = NUM_AREGS - 1; r >= 1; r--)
            if (cdb_hit[r]) o_rf_waddr = 5'(r);
    end

    always_comb begin
        o_rs1_pending = (i_dec_rs1 != 5'd0) & rst_pend[i_dec_rs1];
        o_rs2_pending = (i_dec_rs2 != 5'd0) & rst_pend[i_dec_rs2];
`ifdef CDB_BYPASS_EN
        o_rs1_pending = o_rs1_pending & ~cdb_hit[i_dec_rs1];
        o_rs2_pending = o_rs2_pending & ~cdb_hit[i_dec_rs2];
`else
        o_rs1_pending = o_rs1_pending & 1'b1;
        o_rs2_pending = o_rs2_pending & 1'b1;
`endif
        o_rs1_tag = rst_tag[i_dec_rs1];
        o_rs2_tag = rst_tag[i_dec_rs2];
    end

    // INIT rewrites every slot, so the array itself needs no reset.
    always_ff @(posedge i_clk) begin
        if (state == INIT)
            free_list[init_cnt] <= init_cnt;
        else if (push)
            free_list[tail] <= i_cdb_tag;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= INIT;
            init_cnt    <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            rst_pend    <= '0;
            flush_q     <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    count    <= (TAG_W+1)'(init_cnt) + (TAG_W+1)'(1);
                    if (init_cnt == '1) begin
                        state       <= RUN;
                        init_done_q <= 1'b1;
                        head        <= '0;
                        tail        <= '0;
                    end
                end
                RUN:     if (fire & i_dec_is_branch) state <= BR_WAIT;
                BR_WAIT: if (i_cdb_branch) state <= RUN;
                default: state <= INIT;
            endcase
            if (state != INIT) begin
                flush_q <= i_cdb_branch & i_cdb_branch_taken;
                if (pop)  head <= head + 1'b1;
                if (push) tail <= tail + 1'b1;
                if (cdb_live & list_full) err_q <= 1'b1;
                case ({pop, push})
                    2'b10:   count <= count - 1'b1;
                    2'b01:   count <= count + 1'b1;
                    default: count <= count;
                endcase
                // A fresh allocation to a register outranks a CDB clear of its old tag.
                for (int r = 1; r < NUM_AREGS; r++) begin
                    if (pop && (int'(i_dec_rd) == r)) begin
                        rst_pend[r] <= 1'b1;
                        rst_tag[r]  <= free_list[head];
                    end else if (cdb_hit[r]) begin
                        rst_pend[r] <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_dispatch_ctrl_param.sv
// Bench for dispatch_ctrl_param: directed scenarios plus randomized traffic against a queue-based model.
module tb_dispatch_ctrl_param;
    localparam int NQ = 4;
    localparam int TW = 6;
    localparam int NT = 64;
`ifdef CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_dec_valid;
    logic [1:0]    i_dec_qsel;
    logic [4:0]    i_dec_rd;
    logic          i_dec_rd_we;
    logic [4:0]    i_dec_rs1;
    logic [4:0]    i_dec_rs2;
    logic          i_dec_is_branch;
    logic          o_dec_ready;
    logic [NQ-1:0] i_queue_full;
    logic [NQ-1:0] o_disp_valid;
    logic [TW-1:0] o_rd_tag;
    logic          o_rs1_pending;
    logic          o_rs2_pending;
    logic [TW-1:0] o_rs1_tag;
    logic [TW-1:0] o_rs2_tag;
    logic          i_cdb_valid;
    logic [TW-1:0] i_cdb_tag;
    logic          i_cdb_branch;
    logic          i_cdb_branch_taken;
    logic          o_rf_wen;
    logic [4:0]    o_rf_waddr;
    logic          o_flush;
    logic          o_init_done;
    logic [TW:0]   o_free_cnt;
    logic          o_err;
    logic [1:0]    o_dbg_state;

    always #5 i_clk = ~i_clk;

    dispatch_ctrl_param dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_dec_valid(i_dec_valid), .i_dec_qsel(i_dec_qsel), .i_dec_rd(i_dec_rd),
        .i_dec_rd_we(i_dec_rd_we), .i_dec_rs1(i_dec_rs1), .i_dec_rs2(i_dec_rs2),
        .i_dec_is_branch(i_dec_is_branch), .o_dec_ready(o_dec_ready),
        .i_queue_full(i_queue_full), .o_disp_valid(o_disp_valid), .o_rd_tag(o_rd_tag),
        .o_rs1_pending(o_rs1_pending), .o_rs2_pending(o_rs2_pending),
        .o_rs1_tag(o_rs1_tag), .o_rs2_tag(o_rs2_tag),
        .i_cdb_valid(i_cdb_valid), .i_cdb_tag(i_cdb_tag), .i_cdb_branch(i_cdb_branch),
        .i_cdb_branch_taken(i_cdb_branch_taken), .o_rf_wen(o_rf_wen), .o_rf_waddr(o_rf_waddr),
        .o_flush(o_flush), .o_init_done(o_init_done), .o_free_cnt(o_free_cnt), .o_err(o_err),
        .o_dbg_state(o_dbg_state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: free tags as an ordered queue, per-register pending/tag, stall flag.
    bit  m_inited;
    int  m_init_cycles;
    bit  m_stalled;
    int  m_fl[$];
    bit  m_pend[32];
    int  m_tag[32];
    bit  m_err;
    bit  m_flush;

    bit       e_fire;
    bit       e_alloc;
    logic [3:0] e_disp;
    int       e_rd_tag;
    bit       e_rs1_p;
    bit       e_rs2_p;
    bit       e_wen;
    int       e_waddr;

    function automatic void model_reset();
        m_inited = 0; m_init_cycles = 0; m_stalled = 0; m_err = 0; m_flush = 0;
        m_fl.delete();
        for (int r = 0; r < 32; r++) begin m_pend[r] = 0; m_tag[r] = 0; end
    endfunction

    function automatic void model_eval();
        e_alloc  = i_dec_rd_we && (i_dec_rd != 0);
        e_fire   = m_inited && !m_stalled && i_dec_valid && !i_queue_full[i_dec_qsel]
                   && (!e_alloc || m_fl.size() > 0);
        e_disp   = e_fire ? (4'b0001 << i_dec_qsel) : 4'b0000;
        e_rd_tag = (m_fl.size() > 0) ? m_fl[0] : -1;
        e_wen = 0; e_waddr = 0;
        if (m_inited && i_cdb_valid)
            for (int r = 31; r >= 1; r--)
                if (m_pend[r] && m_tag[r] == int'(i_cdb_tag)) begin e_wen = 1; e_waddr = r; end
        e_rs1_p = (i_dec_rs1 != 0) && m_pend[i_dec_rs1];
        e_rs2_p = (i_dec_rs2 != 0) && m_pend[i_dec_rs2];
        if (BYP && m_inited && i_cdb_valid) begin
            if (m_tag[i_dec_rs1] == int'(i_cdb_tag)) e_rs1_p = 0;
            if (m_tag[i_dec_rs2] == int'(i_cdb_tag)) e_rs2_p = 0;
        end
    endfunction

    // Advance one clock edge; the model applies the same edge's effects.
    task automatic step();
        bit was_full;
        int t;
        model_eval();
        if (i_rst) begin
            model_reset();
        end else if (!m_inited) begin
            m_flush = 0;
            m_init_cycles++;
            if (m_init_cycles == NT) begin
                m_inited = 1;
                m_fl.delete();
                for (int k = 0; k < NT; k++) m_fl.push_back(k);
            end
        end else begin
            was_full = (m_fl.size() == NT);
            m_flush = i_cdb_branch && i_cdb_branch_taken;
            if (i_cdb_valid)
                for (int r = 1; r < 32; r++)
                    if (m_pend[r] && m_tag[r] == int'(i_cdb_tag)) m_pend[r] = 0;
            if (e_fire && e_alloc) begin
                t = m_fl.pop_front();
                m_pend[i_dec_rd] = 1;
                m_tag[i_dec_rd]  = t;
            end
            if (i_cdb_valid) begin
                if (was_full) m_err = 1;
                else m_fl.push_back(int'(i_cdb_tag));
            end
            if (e_fire && i_dec_is_branch) m_stalled = 1;
            else if (m_stalled && i_cdb_branch) m_stalled = 0;
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_idle();
        i_dec_valid = 0; i_dec_qsel = 0; i_dec_rd = 0; i_dec_rd_we = 0;
        i_dec_rs1 = 0; i_dec_rs2 = 0; i_dec_is_branch = 0; i_queue_full = 0;
        i_cdb_valid = 0; i_cdb_tag = 0; i_cdb_branch = 0; i_cdb_branch_taken = 0;
    endtask

    task automatic test_reset();
        set_idle();
        i_dec_valid = 1; i_dec_rd = 3; i_dec_rd_we = 1;
        i_rst = 1;
        step(); step();
        i_rst = 0; i_dec_rs1 = 5; i_dec_rs2 = 7;
        @(negedge i_clk);
        n_cmp++; if (o_init_done !== 1'b0) begin n_bad++; $display("FAIL reset_init_done: got %b want 0", o_init_done); end
        n_cmp++; if (o_free_cnt !== 7'd0) begin n_bad++; $display("FAIL reset_free_cnt: got %0d want 0", o_free_cnt); end
        n_cmp++; if (o_dec_ready !== 1'b0) begin n_bad++; $display("FAIL reset_dec_ready: got %b want 0", o_dec_ready); end
        n_cmp++; if (o_disp_valid !== 4'b0) begin n_bad++; $display("FAIL reset_disp_valid: got %b want 0000", o_disp_valid); end
        n_cmp++; if (o_rf_wen !== 1'b0) begin n_bad++; $display("FAIL reset_rf_wen: got %b want 0", o_rf_wen); end
        n_cmp++; if (o_flush !== 1'b0) begin n_bad++; $display("FAIL reset_flush: got %b want 0", o_flush); end
        n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", o_err); end
        n_cmp++; if (o_rs1_pending !== 1'b0 || o_rs2_pending !== 1'b0) begin
            n_bad++; $display("FAIL reset_pending: got %b%b want 00", o_rs1_pending, o_rs2_pending); end
        step();
    endtask

    task automatic test_init();
        for (int i = 1; i < NT; i++) begin
            @(negedge i_clk);
            n_cmp++; if (o_dec_ready !== 1'b0 || o_init_done !== 1'b0 || o_free_cnt !== 7'(i)) begin
                n_bad++; $display("FAIL init_cycle %0d: ready %b done %b cnt %0d want 0 0 %0d",
                                  i, o_dec_ready, o_init_done, o_free_cnt, i); end
            step();
        end
        i_dec_valid = 0;
        @(negedge i_clk);
        n_cmp++; if (o_init_done !== 1'b1) begin n_bad++; $display("FAIL init_done_rise: got %b want 1", o_init_done); end
        n_cmp++; if (o_free_cnt !== 7'd64) begin n_bad++; $display("FAIL init_free_cnt: got %0d want 64", o_free_cnt); end
        step();
    endtask

    task automatic test_dispatch();
        set_idle();
        i_dec_valid = 1; i_dec_qsel = 2; i_dec_rd = 5; i_dec_rd_we = 1;
        @(negedge i_clk);
        n_cmp++; if (o_dec_ready !== 1'b1) begin n_bad++; $display("FAIL disp_ready: got %b want 1", o_dec_ready); end
        n_cmp++; if (o_disp_valid !== 4'b0100) begin n_bad++; $display("FAIL disp_onehot: got %b want 0100", o_disp_valid); end
        n_cmp++; if (o_rd_tag !== 6'd0) begin n_bad++; $display("FAIL disp_rd_tag: got %0d want 0", o_rd_tag); end
        step();
        set_idle(); i_dec_rs1 = 5;
        @(negedge i_clk);
        n_cmp++; if (o_rs1_pending !== 1'b1 || o_rs1_tag !== 6'd0) begin
            n_bad++; $display("FAIL disp_rs1_read: got p%b t%0d want p1 t0", o_rs1_pending, o_rs1_tag); end
        n_cmp++; if (o_free_cnt !== 7'd63) begin n_bad++; $display("FAIL disp_free_cnt: got %0d want 63", o_free_cnt); end
        step();
        i_cdb_valid = 1; i_cdb_tag = 0;
        @(negedge i_clk);
        n_cmp++; if (o_rf_wen !== 1'b1 || o_rf_waddr !== 5'd5) begin
            n_bad++; $display("FAIL cdb_wb: got wen %b addr %0d want 1 5", o_rf_wen, o_rf_waddr); end
        n_cmp++; if (o_rs1_pending !== !BYP) begin
            n_bad++; $display("FAIL cdb_same_cycle_pending: got %b want %b", o_rs1_pending, !BYP); end
        step();
        i_cdb_valid = 0;
        @(negedge i_clk);
        n_cmp++; if (o_rs1_pending !== 1'b0 || o_free_cnt !== 7'd64) begin
            n_bad++; $display("FAIL cdb_after: got p%b cnt %0d want p0 cnt 64", o_rs1_pending, o_free_cnt); end
        step();
    endtask

    task automatic test_err();
        set_idle();
        i_cdb_valid = 1; i_cdb_tag = 9;
        @(negedge i_clk);
        n_cmp++; if (o_rf_wen !== 1'b0 || o_err !== 1'b0) begin
            n_bad++; $display("FAIL err_pre: got wen %b err %b want 0 0", o_rf_wen, o_err); end
        step();
        set_idle();
        @(negedge i_clk);
        n_cmp++; if (o_err !== 1'b1 || o_free_cnt !== 7'd64) begin
            n_bad++; $display("FAIL err_overflow: got err %b cnt %0d want 1 64", o_err, o_free_cnt); end
        step();
    endtask

    task automatic test_full_branch();
        set_idle();
        i_dec_valid = 1; i_dec_qsel = 1; i_queue_full = 4'b0010; i_dec_is_branch = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            n_cmp++; if (o_dec_ready !== 1'b0 || o_disp_valid !== 4'b0) begin
                n_bad++; $display("FAIL full_hold %0d: got ready %b disp %b want 0 0000", i, o_dec_ready, o_disp_valid); end
            step();
        end
        i_queue_full = 0;
        @(negedge i_clk);
        n_cmp++; if (o_dec_ready !== 1'b1 || o_disp_valid !== 4'b0010) begin
            n_bad++; $display("FAIL full_release: got ready %b disp %b want 1 0010", o_dec_ready, o_disp_valid); end
        step();
        for (int i = 0; i < 3; i++) begin
            i_dec_qsel = 2'(i);
            @(negedge i_clk);
            n_cmp++; if (o_dec_ready !== 1'b0 || o_disp_valid !== 4'b0) begin
                n_bad++; $display("FAIL br_stall %0d: got ready %b disp %b want 0 0000", i, o_dec_ready, o_disp_valid); end
            step();
        end
        i_cdb_branch = 1; i_cdb_branch_taken = 1;
        @(negedge i_clk);
        n_cmp++; if (o_dec_ready !== 1'b0 || o_flush !== 1'b0) begin
            n_bad++; $display("FAIL br_resolve: got ready %b flush %b want 0 0", o_dec_ready, o_flush); end
        step();
        i_cdb_branch = 0; i_cdb_branch_taken = 0; i_dec_is_branch = 0; i_dec_qsel = 1;
        @(negedge i_clk);
        n_cmp++; if (o_flush !== 1'b1 || o_dec_ready !== 1'b1) begin
            n_bad++; $display("FAIL br_flush: got flush %b ready %b want 1 1", o_flush, o_dec_ready); end
        step();
        i_dec_valid = 0;
        @(negedge i_clk);
        n_cmp++; if (o_flush !== 1'b0) begin n_bad++; $display("FAIL br_flush_pulse: got %b want 0", o_flush); end
        step();
    endtask

    task automatic test_same_cycle();
        int old_t;
        int new_t;
        set_idle();
        i_dec_valid = 1; i_dec_rd = 7; i_dec_rd_we = 1;
        old_t = m_fl[0];
        @(negedge i_clk);
        n_cmp++; if (o_dec_ready !== 1'b1 || o_rd_tag !== 6'(old_t)) begin
            n_bad++; $display("FAIL same_first: got ready %b tag %0d want 1 %0d", o_dec_ready, o_rd_tag, old_t); end
        step();
        i_cdb_valid = 1; i_cdb_tag = 6'(old_t);
        new_t = m_fl[0];
        @(negedge i_clk);
        n_cmp++; if (o_rf_wen !== 1'b1 || o_rf_waddr !== 5'd7 || o_rd_tag !== 6'(new_t)) begin
            n_bad++; $display("FAIL same_cycle: got wen %b addr %0d tag %0d want 1 7 %0d",
                              o_rf_wen, o_rf_waddr, o_rd_tag, new_t); end
        step();
        set_idle(); i_dec_rs1 = 7;
        @(negedge i_clk);
        n_cmp++; if (o_rs1_pending !== 1'b1 || o_rs1_tag !== 6'(new_t)) begin
            n_bad++; $display("FAIL same_rst7: got p%b t%0d want p1 t%0d", o_rs1_pending, o_rs1_tag, new_t); end
        step();
    endtask

    task automatic test_random();
        int outs[$];
        for (int c = 0; c < 500; c++) begin
            i_dec_valid = ($urandom_range(0, 3) != 0);
            i_dec_qsel  = 2'($urandom_range(0, 3));
            i_dec_rd    = 5'($urandom_range(0, 31));
            i_dec_rd_we = ($urandom_range(0, 3) != 0);
            i_dec_rs1   = 5'($urandom_range(0, 31));
            i_dec_rs2   = 5'($urandom_range(0, 31));
            i_dec_is_branch = ($urandom_range(0, 15) == 0);
            i_queue_full = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            outs.delete();
            for (int t = 0; t < NT; t++) begin
                int hits[$];
                hits = m_fl.find_index with (item == t);
                if (hits.size() == 0) outs.push_back(t);
            end
            if (outs.size() > 0 && $urandom_range(0, 1) == 1) begin
                i_cdb_valid = 1;
                i_cdb_tag = 6'(outs[$urandom_range(0, outs.size() - 1)]);
            end else begin
                i_cdb_valid = 0;
                i_cdb_tag = 6'($urandom_range(0, 63));
            end
            i_cdb_branch = m_stalled && ($urandom_range(0, 3) == 0);
            i_cdb_branch_taken = i_cdb_branch && ($urandom_range(0, 1) == 1);
            @(negedge i_clk);
            model_eval();
            n_cmp++; if (o_dec_ready !== e_fire || o_disp_valid !== e_disp) begin
                n_bad++; $display("FAIL rnd_fire c%0d: got %b %b want %b %b", c, o_dec_ready, o_disp_valid, e_fire, e_disp); end
            if (e_fire && e_alloc) begin
                n_cmp++; if (o_rd_tag !== 6'(e_rd_tag)) begin
                    n_bad++; $display("FAIL rnd_rd_tag c%0d: got %0d want %0d", c, o_rd_tag, e_rd_tag); end
            end
            n_cmp++; if (o_rs1_pending !== e_rs1_p || o_rs2_pending !== e_rs2_p) begin
                n_bad++; $display("FAIL rnd_pending c%0d: got %b%b want %b%b", c, o_rs1_pending, o_rs2_pending, e_rs1_p, e_rs2_p); end
            if (e_rs1_p) begin
                n_cmp++; if (o_rs1_tag !== 6'(m_tag[i_dec_rs1])) begin
                    n_bad++; $display("FAIL rnd_rs1_tag c%0d: got %0d want %0d", c, o_rs1_tag, m_tag[i_dec_rs1]); end
            end
            if (e_rs2_p) begin
                n_cmp++; if (o_rs2_tag !== 6'(m_tag[i_dec_rs2])) begin
                    n_bad++; $display("FAIL rnd_rs2_tag c%0d: got %0d want %0d", c, o_rs2_tag, m_tag[i_dec_rs2]); end
            end
            n_cmp++; if (o_rf_wen !== e_wen || (e_wen && o_rf_waddr !== 5'(e_waddr))) begin
                n_bad++; $display("FAIL rnd_wb c%0d: got %b %0d want %b %0d", c, o_rf_wen, o_rf_waddr, e_wen, e_waddr); end
            n_cmp++; if (o_free_cnt !== 7'(m_fl.size())) begin
                n_bad++; $display("FAIL rnd_free_cnt c%0d: got %0d want %0d", c, o_free_cnt, m_fl.size()); end
            n_cmp++; if (o_flush !== m_flush || o_err !== m_err || o_init_done !== m_inited) begin
                n_bad++; $display("FAIL rnd_status c%0d: got f%b e%b d%b want f%b e%b d%b",
                                  c, o_flush, o_err, o_init_done, m_flush, m_err, m_inited); end
            step();
        end
        set_idle();
        step();
    endtask

    task automatic test_exhaust();
        set_idle();
        for (int i = 0; i < NT; i++) begin
            i_dec_valid = 1; i_dec_rd_we = 1; i_dec_rd = 5'((i % 31) + 1); i_dec_qsel = 2'(i % 4);
            @(negedge i_clk);
            n_cmp++; if (o_dec_ready !== 1'b1 || o_rd_tag !== 6'(i)) begin
                n_bad++; $display("FAIL exh_alloc %0d: got ready %b tag %0d want 1 %0d", i, o_dec_ready, o_rd_tag, i); end
            step();
        end
        i_dec_rd = 9;
        for (int i = 0; i < 2; i++) begin
            @(negedge i_clk);
            n_cmp++; if (o_dec_ready !== 1'b0 || o_free_cnt !== 7'd0) begin
                n_bad++; $display("FAIL exh_hold %0d: got ready %b cnt %0d want 0 0", i, o_dec_ready, o_free_cnt); end
            step();
        end
        i_cdb_valid = 1; i_cdb_tag = 6'd39;
        @(negedge i_clk);
        n_cmp++; if (o_dec_ready !== 1'b0 || o_rf_wen !== 1'b1 || o_rf_waddr !== 5'd9) begin
            n_bad++; $display("FAIL exh_return: got ready %b wen %b addr %0d want 0 1 9", o_dec_ready, o_rf_wen, o_rf_waddr); end
        step();
        i_cdb_valid = 0;
        @(negedge i_clk);
        n_cmp++; if (o_dec_ready !== 1'b1 || o_rd_tag !== 6'd39) begin
            n_bad++; $display("FAIL exh_refire: got ready %b tag %0d want 1 39", o_dec_ready, o_rd_tag); end
        step();
        set_idle();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        i_rst = 1;
        model_reset();
        test_reset();
        test_init();
        test_dispatch();
        test_err();
        test_full_branch();
        test_same_cycle();
        test_random();
        test_reset();
        test_init();
        test_exhaust();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
